daqdepacketizer: RTL and testbench

//  Reader for the DAQ packet stream held in the sample FIFO. Each packet is

---
 rtl/daqdepacketizer.sv | 171 +++++++++++++++++
 tb/tb_daqdepacketizer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/daqdepacketizer.sv
// DAQ packet stream reader: pops a FWFT sample FIFO, locks to the preamble, checks
// packet-counter continuity and emits (daq, adc)-tagged samples. Option: DEPKT_STATS_EN.
module daqdepacketizer #(
  parameter int unsigned ADC_COUNT    = 8,
  parameter int unsigned DAQ_COUNT    = 8,
  parameter logic [15:0] PREAMBLE_VAL = 16'hAAAA
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [15:0] fifo_rd_data_i,
  input  logic        fifo_rd_empty_i,
  output logic        fifo_rd_en_o,
  output logic [15:0] sample_data_o,
  output logic [2:0]  sample_daq_o,
  output logic [2:0]  sample_adc_o,
  output logic        sample_first_o,
  output logic        sample_last_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic [15:0] pkt_count_o,
  output logic        locked_o,
  output logic        pkt_gap_o,
  output logic        sync_lost_o
`ifdef DEPKT_STATS_EN
  ,
  output logic [31:0] gap_total_o,
  output logic [15:0] resync_total_o
`endif
);

  localparam logic [2:0] ADC_LAST = 3'(ADC_COUNT - 1);
  localparam logic [2:0] DAQ_LAST = 3'(DAQ_COUNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    EXPECT = 2'd3
  } state_t;

  state_t      state_r;
  logic        first_pkt_r;
  logic [15:0] exp_cnt_r;
  logic [2:0]  daq_idx_r;
  logic [2:0]  adc_idx_r;
  logic        pop_ok_s;
  logic        pop_s;
  logic        is_pre_s;
  logic        idx_last_s;
  logic        is_gap_s;

`ifdef DEPKT_STATS_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [15:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {17'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction
`endif

  // DATA only advances when the output register is free or being drained this cycle
  always_comb begin
    pop_ok_s = 1'b0;
    case (state_r)
      HUNT, HEADER, EXPECT: pop_ok_s = 1'b1;
      DATA:                 pop_ok_s = ~sample_valid_o | sample_ready_i;
      default:              pop_ok_s = 1'b0;
    endcase
  end

  assign pop_s        = en_i & ~fifo_rd_empty_i & ~reset_i & pop_ok_s;
  assign fifo_rd_en_o = pop_s;
  assign is_pre_s     = (fifo_rd_data_i == PREAMBLE_VAL);
  assign idx_last_s   = (daq_idx_r == DAQ_LAST) && (adc_idx_r == ADC_LAST);
  assign is_gap_s     = ~first_pkt_r && (fifo_rd_data_i != exp_cnt_r);

  // Framing state machine with registered sample stream and status pulses
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= HUNT;
      first_pkt_r    <= 1'b1;
      exp_cnt_r      <= 16'd0;
      daq_idx_r      <= 3'd0;
      adc_idx_r      <= 3'd0;
      sample_data_o  <= 16'd0;
      sample_daq_o   <= 3'd0;
      sample_adc_o   <= 3'd0;
      sample_first_o <= 1'b0;
      sample_last_o  <= 1'b0;
      sample_valid_o <= 1'b0;
      pkt_count_o    <= 16'd0;
      locked_o       <= 1'b0;
      pkt_gap_o      <= 1'b0;
      sync_lost_o    <= 1'b0;
`ifdef DEPKT_STATS_EN
      gap_total_o    <= 32'd0;
      resync_total_o <= 16'd0;
`endif
    end else begin
      pkt_gap_o   <= 1'b0;
      sync_lost_o <= 1'b0;
      // an accepted sample retires unless DATA reloads the register below
      if (sample_valid_o && sample_ready_i) begin
        sample_valid_o <= 1'b0;
      end
      if (pop_s) begin
        case (state_r)
          HUNT: begin
            locked_o <= 1'b0;
            if (is_pre_s) begin
              state_r <= HEADER;
            end
          end
          HEADER: begin
            pkt_count_o <= fifo_rd_data_i;
            if (is_gap_s) begin
              pkt_gap_o <= 1'b1;
`ifdef DEPKT_STATS_EN
              gap_total_o <= sat_add32(gap_total_o, fifo_rd_data_i - exp_cnt_r);
`endif
            end
            exp_cnt_r   <= fifo_rd_data_i + 16'd1;
            first_pkt_r <= 1'b0;
            locked_o    <= 1'b1;
            daq_idx_r   <= 3'd0;
            adc_idx_r   <= 3'd0;
            state_r     <= DATA;
          end
          DATA: begin
            sample_data_o  <= fifo_rd_data_i;
            sample_daq_o   <= daq_idx_r;
            sample_adc_o   <= adc_idx_r;
            sample_first_o <= (daq_idx_r == 3'd0) && (adc_idx_r == 3'd0);
            sample_last_o  <= idx_last_s;
            sample_valid_o <= 1'b1;
            if (adc_idx_r == ADC_LAST) begin
              adc_idx_r <= 3'd0;
              daq_idx_r <= daq_idx_r + 3'd1;
            end else begin
              adc_idx_r <= adc_idx_r + 3'd1;
            end
            if (idx_last_s) begin
              state_r <= EXPECT;
            end
          end
          EXPECT: begin
            if (is_pre_s) begin
              state_r <= HEADER;
            end else begin
              sync_lost_o <= 1'b1;
              locked_o    <= 1'b0;
              first_pkt_r <= 1'b1;
              state_r     <= HUNT;
`ifdef DEPKT_STATS_EN
              resync_total_o <= sat_inc16(resync_total_o);
`endif
            end
          end
          default: begin
            state_r <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daqdepacketizer.sv
// Self-checking bench for daqdepacketizer: FWFT FIFO model, random payload/backpressure,
// expected sample stream derived from how each packet was constructed.
module tb_daqdepacketizer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic [15:0] fifo_rd_data_i;
  logic        fifo_rd_empty_i;
  logic        fifo_rd_en_o;
  logic [15:0] sample_data_o;
  logic [2:0]  sample_daq_o;
  logic [2:0]  sample_adc_o;
  logic        sample_first_o;
  logic        sample_last_o;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic [15:0] pkt_count_o;
  logic        locked_o;
  logic        pkt_gap_o;
  logic        sync_lost_o;
`ifdef DEPKT_STATS_EN
  logic [31:0] gap_total_o;
  logic [15:0] resync_total_o;
`endif

  always #5 clk = ~clk;

  daqdepacketizer dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .fifo_rd_data_i(fifo_rd_data_i), .fifo_rd_empty_i(fifo_rd_empty_i),
    .fifo_rd_en_o(fifo_rd_en_o), .sample_data_o(sample_data_o),
    .sample_daq_o(sample_daq_o), .sample_adc_o(sample_adc_o),
    .sample_first_o(sample_first_o), .sample_last_o(sample_last_o),
    .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
    .pkt_count_o(pkt_count_o), .locked_o(locked_o),
    .pkt_gap_o(pkt_gap_o), .sync_lost_o(sync_lost_o)
`ifdef DEPKT_STATS_EN
    , .gap_total_o(gap_total_o), .resync_total_o(resync_total_o)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  daq;
    logic [2:0]  adc;
    logic        first;
    logic        last;
  } samp_t;

  samp_t       exp_q[$];
  samp_t       got_q[$];
  logic [15:0] fq[$];
  int          tests = 0;
  int          fails = 0;
  int          gap_seen = 0;
  int          sync_seen = 0;
  int unsigned ready_pct = 100;
  int unsigned hole_pct = 0;
  logic        prev_stall = 1'b0;
  samp_t       prev_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive_inputs();
    logic hole;
    hole = ($urandom_range(99) < hole_pct);
    if (fq.size() > 0 && !hole) begin
      fifo_rd_data_i  = fq[0];
      fifo_rd_empty_i = 1'b0;
    end else begin
      fifo_rd_data_i  = 16'h0000;
      fifo_rd_empty_i = 1'b1;
    end
    sample_ready_i = ($urandom_range(99) < ready_pct);
  endtask

  // one clock: observe just after negedge, pop the FIFO model on posedge, re-drive at negedge
  task automatic step();
    logic  pop_v;
    samp_t cur;
    #1;
    pop_v = fifo_rd_en_o;
    cur   = {sample_data_o, sample_daq_o, sample_adc_o, sample_first_o, sample_last_o};
    if (prev_stall) check("hold_under_backpressure", 32'(cur), 32'(prev_s));
    if (pop_v) check("pop_only_when_nonempty", 32'(fifo_rd_empty_i), 32'd0);
    if (sample_valid_o && sample_ready_i) got_q.push_back(cur);
    if (pkt_gap_o) gap_seen++;
    if (sync_lost_o) sync_seen++;
    prev_stall = sample_valid_o & ~sample_ready_i & ~reset_i;
    prev_s     = cur;
    @(posedge clk);
    if (pop_v) void'(fq.pop_front());
    @(negedge clk);
    drive_inputs();
  endtask

  task automatic push_packet(input logic [15:0] hdr, input bit fixed, input bit force_pre);
    logic [15:0] w;
    samp_t       s;
    fq.push_back(16'hAAAA);
    fq.push_back(hdr);
    for (int i = 0; i < 64; i++) begin
      w = 16'($urandom_range(32'hFFFF));
      if ($urandom_range(7) == 0) w = 16'hAAAA;
      if (force_pre && i == 5) w = 16'hAAAA;
      if (fixed) w = 16'h0100 + 16'(i);
      fq.push_back(w);
      s.data  = w;
      s.daq   = 3'(i / 8);
      s.adc   = 3'(i % 8);
      s.first = (i == 0);
      s.last  = (i == 63);
      exp_q.push_back(s);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((fq.size() > 0 || sample_valid_o) && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_drain_in_budget"}, 32'(n < 3000), 32'd1);
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic compare_samples(input string tag);
    check({tag, "_sample_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_sample"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    fq.delete();
    drive_inputs();
    step();
    step();
    reset_i = 1'b0;
    got_q.delete();
    exp_q.delete();
    gap_seen  = 0;
    sync_seen = 0;
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    check({tag, "_flags"}, 32'({sample_valid_o, locked_o, pkt_gap_o, sync_lost_o,
                                fifo_rd_en_o, sample_first_o, sample_last_o}), 32'd0);
    check({tag, "_fields"}, {sample_data_o, pkt_count_o}, 32'd0);
    check({tag, "_index"}, 32'({sample_daq_o, sample_adc_o}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          nj;
    logic [15:0] w;
    reset_i = 1'b1;
    en_i    = 1'b1;
    drive_inputs();
    @(negedge clk);
    do_reset();
    check_reset_state("reset");

    // 1: known packet, full throughput
    push_packet(16'h0005, 1'b1, 1'b0);
    drain("t1");
    compare_samples("t1");
    check("t1_pkt_count", 32'(pkt_count_o), 32'h0005);
    check("t1_locked", 32'(locked_o), 32'd1);
    check("t1_pulses", 32'(gap_seen + sync_seen), 32'd0);

    // 2: junk before the first preamble is discarded
    do_reset();
    nj = int'($urandom_range(5, 1));
    for (int i = 0; i < nj; i++) begin
      w = 16'($urandom_range(32'hFFFF));
      if (w == 16'hAAAA) w = 16'h1234;
      fq.push_back(w);
    end
    drain("t2_junk");
    check("t2_unlocked_hunting", 32'(locked_o), 32'd0);
    compare_samples("t2_junk");
    push_packet(16'h0007, 1'b0, 1'b0);
    drain("t2");
    compare_samples("t2");
    check("t2_locked", 32'(locked_o), 32'd1);
    check("t2_pkt_count", 32'(pkt_count_o), 32'h0007);
    check("t2_no_gap_first", 32'(gap_seen), 32'd0);

    // 3: counter skip 0010 -> 0013 under random backpressure and empty holes
    do_reset();
    ready_pct = 70;
    hole_pct  = 20;
    push_packet(16'h0010, 1'b0, 1'b0);
    push_packet(16'h0013, 1'b0, 1'b0);
    drain("t3");
    compare_samples("t3");
    check("t3_gap_pulses", 32'(gap_seen), 32'd1);
    check("t3_pkt_count", 32'(pkt_count_o), 32'h0013);
`ifdef DEPKT_STATS_EN
    check("t3_gap_total", gap_total_o, 32'd2);
`endif

    // 4: counter wrap is continuous, payload preamble words are data
    do_reset();
    push_packet(16'hFFFF, 1'b0, 1'b1);
    push_packet(16'h0000, 1'b0, 1'b1);
    drain("t4");
    compare_samples("t4");
    check("t4_no_gap_wrap", 32'(gap_seen), 32'd0);
    check("t4_pkt_count", 32'(pkt_count_o), 32'h0000);

    // 5: missing preamble drops lock, then relock without gap report
    fq.push_back(16'h5555);
    drain("t5_lost");
    check("t5_sync_lost", 32'(sync_seen), 32'd1);
    check("t5_unlocked", 32'(locked_o), 32'd0);
`ifdef DEPKT_STATS_EN
    check("t5_resync_total", 32'(resync_total_o), 32'd1);
`endif
    push_packet(16'h0100 + 16'($urandom_range(255)), 1'b0, 1'b0);
    drain("t5");
    compare_samples("t5");
    check("t5_relocked", 32'(locked_o), 32'd1);
    check("t5_no_gap_after_relock", 32'(gap_seen), 32'd0);

    // 6: reset in the middle of a stalled/bursty stream
    do_reset();
    ready_pct = 50;
    hole_pct  = 25;
    push_packet(16'h0020, 1'b0, 1'b0);
    push_packet(16'h0021, 1'b0, 1'b0);
    n = 0;
    while (got_q.size() < 30 && n < 3000) begin
      step();
      n++;
    end
    check("t6_reach_30_in_budget", 32'(n < 3000), 32'd1);
    check("t6_count_before_reset", 32'(got_q.size()), 32'd30);
    for (int i = 0; i < 30 && i < got_q.size(); i++)
      check("t6_sample_before_reset", 32'(got_q[i]), 32'(exp_q[i]));
    do_reset();
    #1;
    check("t6_valid_after_reset", 32'(sample_valid_o), 32'd0);
    check("t6_locked_after_reset", 32'(locked_o), 32'd0);
    push_packet(16'h0040, 1'b0, 1'b0);
    drain("t6_post");
    compare_samples("t6_post");
    check("t6_post_no_gap", 32'(gap_seen), 32'd0);
    check("t6_post_pkt_count", 32'(pkt_count_o), 32'h0040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
